sum_collector: RTL and testbench

//  Downstream stage of the registered 4-bit adder. Captures each {Overflow,Sum}

---
 rtl/sum_pkg.sv | 21 ++
 rtl/sum_fifo_mem.sv | 26 ++
 rtl/sum_collector.sv | 116 +++++++++++
 tb/tb_sum_collector.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// sum_pkg: shared widths and constants for the sum_collector slice.
// Optional feature macro used by this slice: OVF_COUNT_EN.
package sum_pkg;

  localparam int SUM_WIDTH = 4;
  localparam int ENTRY_W   = SUM_WIDTH + 1;
  localparam int OVF_CNT_W = 8;
  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = 8'hFF;

  // Saturating increment for the overflow counter.
  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    logic [OVF_CNT_W-1:0] res;
    if (v == OVF_CNT_MAX) begin
      res = v;
    end else begin
      res = v + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sum_fifo_mem.sv
// sum_fifo_mem: DEPTH x EW register array, synchronous write, combinational read.
// Storage is deliberately not reset; validity is tracked by the owner's Count.
module sum_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int EW    = 5
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [EW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [EW-1:0]            o_rdata
);

  logic [EW-1:0] r_mem [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sum_collector.sv
// sum_collector: captures {Overflow,Sum} results from the registered adder into a
// first-word-fall-through FIFO with a valid/ready consumer side. Pulses Drop when
// an input is lost on a full buffer. Build macro OVF_COUNT_EN enables a saturating
// counter of accepted overflowed entries on Ovf_Cnt; otherwise Ovf_Cnt reads 8'h00.
module sum_collector
  import sum_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     In_Valid,
  input  logic [WIDTH-1:0]         Sum,
  input  logic                     Overflow,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [WIDTH:0]           Out_Data,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Drop,
  output logic [OVF_CNT_W-1:0]     Ovf_Cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_valid;
  logic           r_full;
  logic           r_drop;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  w_count_nxt;
  logic [WIDTH:0] w_wr_data;
  logic [WIDTH:0] w_rd_data;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_pop     = r_valid && Out_Ready;
  assign w_push    = In_Valid && (!r_full || w_pop);
  assign w_wr_data = {Overflow, Sum};

  // Next occupancy: both or neither leave Count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy, registered flags and the drop pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != CW'(0));
      r_full  <= (w_count_nxt == CNT_FULL);
      r_drop  <= In_Valid && r_full && !w_pop;
    end
  end

  sum_fifo_mem #(
    .DEPTH (DEPTH),
    .EW    (WIDTH + 1)
  ) u_mem (
    .i_clk   (Clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign Out_Valid = r_valid;
  assign Out_Data  = r_valid ? w_rd_data : {(WIDTH + 1){1'b0}};
  assign Count     = r_count;
  assign Full      = r_full;
  assign Drop      = r_drop;

`ifdef OVF_COUNT_EN
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  // Count accepted entries carrying Overflow=1; discarded inputs never count.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ovf_cnt <= 8'h00;
    end else if (w_push && Overflow) begin
      r_ovf_cnt <= sat_inc(r_ovf_cnt);
    end else begin
      r_ovf_cnt <= r_ovf_cnt;
    end
  end

  assign Ovf_Cnt = r_ovf_cnt;
`else
  assign Ovf_Cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sum_collector.sv
// Scoreboard bench for sum_collector: stimulus pushes expected entries into a
// queue, a negedge monitor pops and compares on every accepted output.
module tb_sum_collector;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       In_Valid;
  logic [3:0] Sum;
  logic       Overflow;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [4:0] Out_Data;
  logic [2:0] Count;
  logic       Full;
  logic       Drop;
  logic [7:0] Ovf_Cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] sb [$];

  sum_collector dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .Sum       (Sum),
    .Overflow  (Overflow),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Count     (Count),
    .Full      (Full),
    .Drop      (Drop),
    .Ovf_Cnt   (Ovf_Cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive one push for this cycle and record it as expected output.
  task automatic drive_push(input logic [4:0] d, input bit expect_accept);
    In_Valid = 1'b1;
    Overflow = d[4];
    Sum      = d[3:0];
    if (expect_accept) sb.push_back(d);
  endtask

  // Monitor: any handshake seen at the negedge completes at the next posedge.
  always @(negedge Clk) begin
    if (Rst_n && Out_Valid && Out_Ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", {27'd0, Out_Data}, 32'hFFFF_FFFF);
      end else begin
        chk("pop_data", {27'd0, Out_Data}, {27'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    Rst_n = 1'b0; In_Valid = 1'b0; Sum = 4'h0; Overflow = 1'b0; Out_Ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst_count", {29'd0, Count}, 32'd0);
    chk("rst_full",  {31'd0, Full}, 32'd0);
    chk("rst_drop",  {31'd0, Drop}, 32'd0);
    chk("rst_ovf",   {24'd0, Ovf_Cnt}, 32'd0);
    chk("rst_data",  {27'd0, Out_Data}, 32'd0);
    @(negedge Clk); Rst_n = 1'b1;
    tick();

    // 1: single push, visible next cycle, then popped
    drive_push(5'h03, 1'b1);
    tick();
    In_Valid = 1'b0;
    chk("t1_valid", {31'd0, Out_Valid}, 32'd1);
    chk("t1_data",  {27'd0, Out_Data}, 32'h03);
    chk("t1_count", {29'd0, Count}, 32'd1);
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    chk("t1_count0", {29'd0, Count}, 32'd0);
    chk("t1_valid0", {31'd0, Out_Valid}, 32'd0);
    chk("t1_data0",  {27'd0, Out_Data}, 32'd0);

    // 2: fill, drop on 5th, drain in order
    drive_push(5'h11, 1'b1); tick();
    drive_push(5'h02, 1'b1); tick();
    drive_push(5'h13, 1'b1); tick();
    drive_push(5'h04, 1'b1); tick();
    chk("t2_full",  {31'd0, Full}, 32'd1);
    chk("t2_count", {29'd0, Count}, 32'd4);
    drive_push(5'h05, 1'b0); tick();
    In_Valid = 1'b0;
    chk("t2_drop",   {31'd0, Drop}, 32'd1);
    chk("t2_count4", {29'd0, Count}, 32'd4);
    tick();
    chk("t2_drop_pulse", {31'd0, Drop}, 32'd0);
    Out_Ready = 1'b1;
    repeat (4) tick();
    Out_Ready = 1'b0;
    chk("t2_drained", {29'd0, Count}, 32'd0);

    // 3: full with simultaneous push and pop
    drive_push(5'h01, 1'b1); tick();
    drive_push(5'h12, 1'b1); tick();
    drive_push(5'h03, 1'b1); tick();
    drive_push(5'h14, 1'b1); tick();
    drive_push(5'h15, 1'b1);
    Out_Ready = 1'b1;
    tick();
    In_Valid = 1'b0;
    chk("t3_drop",  {31'd0, Drop}, 32'd0);
    chk("t3_count", {29'd0, Count}, 32'd4);
    chk("t3_full",  {31'd0, Full}, 32'd1);
    repeat (4) tick();
    chk("t3_drained", {29'd0, Count}, 32'd0);

    // Empty with Out_Ready=1: nothing happens
    tick();
    chk("empty_ready_count", {29'd0, Count}, 32'd0);
    chk("empty_ready_valid", {31'd0, Out_Valid}, 32'd0);

    // 4: eight push/pop pairs, pointers wrap twice
    for (int i = 0; i < 8; i++) begin
      drive_push(5'(i), 1'b1);
      tick();
      chk("t4_count_le1", {31'd0, (Count <= 3'd1)}, 32'd1);
    end
    In_Valid = 1'b0;
    tick();
    Out_Ready = 1'b0;
    chk("t4_count0", {29'd0, Count}, 32'd0);

    // 5: async reset while holding three entries
    drive_push(5'h16, 1'b1); tick();
    drive_push(5'h07, 1'b1); tick();
    drive_push(5'h18, 1'b1); tick();
    In_Valid = 1'b0;
    chk("t5_count3", {29'd0, Count}, 32'd3);
    #2;
    Rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t5_rst_valid", {31'd0, Out_Valid}, 32'd0);
    chk("t5_rst_count", {29'd0, Count}, 32'd0);
    tick();
    @(negedge Clk); Rst_n = 1'b1;
    tick();
    drive_push(5'h0A, 1'b1); tick();
    In_Valid = 1'b0;
    chk("t5_valid", {31'd0, Out_Valid}, 32'd1);
    chk("t5_data",  {27'd0, Out_Data}, 32'h0A);
    chk("t5_count", {29'd0, Count}, 32'd1);
    Out_Ready = 1'b1;
    tick();

    // 6: overflow counter over 300 accepted overflowed pushes
    chk("t6_ovf_start", {24'd0, Ovf_Cnt}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      drive_push({1'b1, 4'(i)}, 1'b1);
      tick();
      if (i == 9) begin
`ifdef OVF_COUNT_EN
        chk("t6_ovf_10", {24'd0, Ovf_Cnt}, 32'd10);
`else
        chk("t6_ovf_10", {24'd0, Ovf_Cnt}, 32'd0);
`endif
      end
    end
    In_Valid = 1'b0;
    tick();
    Out_Ready = 1'b0;
`ifdef OVF_COUNT_EN
    chk("t6_ovf_sat", {24'd0, Ovf_Cnt}, 32'hFF);
`else
    chk("t6_ovf_off", {24'd0, Ovf_Cnt}, 32'h00);
`endif
    chk("t6_count0", {29'd0, Count}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
